// File: rtl/vc_switch_n.sv
// vc_switch_n: main FIFO -> NUM_VC virtual-channel FIFOs -> NUM_DEST destination FIFOs.
// The head word's top VC_BITS pick the VC; the next D_BITS pick the destination.
// A round-robin arbiter moves at most one VC head per cycle into a destination.
// An INIT/IDLE/ACTIVE/ERROR FSM latches thresholds and holds sticky error bits.
// Optional build macro VC_SWITCH_COUNT_EN adds per-destination popped-word counters.
module vc_switch_n #(
  parameter int DATA_SIZE  = 6,
  parameter int NUM_VC     = 2,
  parameter int NUM_DEST   = 2,
  parameter int MAIN_DEPTH = 4,
  parameter int VC_DEPTH   = 16,
  parameter int D_DEPTH    = 4,
  parameter int TW         = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          init,
  input  logic [TW-1:0]                 af_thr,
  input  logic [TW-1:0]                 ae_thr,
  input  logic                          push_main,
  input  logic [DATA_SIZE-1:0]          data_in,
  input  logic [NUM_DEST-1:0]           pop_d,
  output logic [NUM_DEST*DATA_SIZE-1:0] data_out,
  output logic [NUM_DEST-1:0]           empty_out,
  output logic [NUM_DEST-1:0]           almost_empty_out,
  output logic                          pause,
  output logic [NUM_VC+NUM_DEST:0]      error_out,
  output logic [1:0]                    state_out,
  output logic                          idle_out,
  output logic                          active_out
`ifdef VC_SWITCH_COUNT_EN
  ,
  output logic [NUM_DEST*16-1:0]        word_count
`endif
);

  localparam int VC_BITS = $clog2(NUM_VC);
  localparam int D_BITS  = $clog2(NUM_DEST);
  localparam int MA      = $clog2(MAIN_DEPTH);
  localparam int VA      = $clog2(VC_DEPTH);
  localparam int DA      = $clog2(D_DEPTH);
  localparam int ERR_W   = 1 + NUM_VC + NUM_DEST;

  localparam logic [TW-1:0] MAIN_LIM  = TW'(MAIN_DEPTH);
  localparam logic [TW-1:0] VC_LIM    = TW'(VC_DEPTH);
  localparam logic [TW-1:0] D_LIM     = TW'(D_DEPTH);
  localparam logic [MA:0]   MAIN_FULL = (MA+1)'(MAIN_DEPTH);
  localparam logic [VA:0]   VC_FULL   = (VA+1)'(VC_DEPTH);
  localparam logic [DA:0]   D_FULL    = (DA+1)'(D_DEPTH);

  typedef enum logic [1:0] {
    S_INIT   = 2'b00,
    S_IDLE   = 2'b01,
    S_ACTIVE = 2'b10,
    S_ERROR  = 2'b11
  } state_t;

  // Thresholds larger than a FIFO's depth behave as the depth itself.
  function automatic logic [TW-1:0] sat_thr(input logic [TW-1:0] thr, input logic [TW-1:0] lim);
    return (thr > lim) ? lim : thr;
  endfunction

  // Control state
  state_t             r_state, w_state_nxt;
  logic [TW-1:0]      r_af, r_ae;
  logic [ERR_W-1:0]   r_err;
  logic [VC_BITS-1:0] r_rr;

  // Main FIFO
  logic [DATA_SIZE-1:0] r_main_mem [MAIN_DEPTH];
  logic [MA-1:0]        r_main_wr, r_main_rd;
  logic [MA:0]          r_main_cnt;

  // VC FIFOs
  logic [DATA_SIZE-1:0] r_vc_mem [NUM_VC][VC_DEPTH];
  logic [VA-1:0]        r_vc_wr  [NUM_VC];
  logic [VA-1:0]        r_vc_rd  [NUM_VC];
  logic [VA:0]          r_vc_cnt [NUM_VC];

  // Destination FIFOs plus the last popped word shown while empty
  logic [DATA_SIZE-1:0] r_d_mem [NUM_DEST][D_DEPTH];
  logic [DA-1:0]        r_d_wr  [NUM_DEST];
  logic [DA-1:0]        r_d_rd  [NUM_DEST];
  logic [DA:0]          r_d_cnt [NUM_DEST];
  logic [DATA_SIZE-1:0] r_hold  [NUM_DEST];

  logic                 w_en;
  logic [TW-1:0]        w_af_main, w_af_vc, w_af_d, w_ae_d;
  logic [DATA_SIZE-1:0] w_main_word;
  logic [VC_BITS-1:0]   w_main_vc;
  logic                 w_main_full, w_main_fwd, w_main_push;
  logic [DATA_SIZE-1:0] w_vc_head [NUM_VC];
  logic [D_BITS-1:0]    w_vc_dst  [NUM_VC];
  logic [NUM_VC-1:0]    w_elig, w_vc_push, w_vc_pop;
  logic                 w_gnt_vld;
  logic [VC_BITS-1:0]   w_gnt, w_idx;
  logic [NUM_DEST-1:0]  w_d_push, w_d_pop;
  logic [DATA_SIZE-1:0] w_d_word;
  logic [ERR_W-1:0]     w_new_err;
  logic                 w_any_ne;

  assign w_en        = (r_state != S_INIT);
  assign w_af_main   = sat_thr(r_af, MAIN_LIM);
  assign w_af_vc     = sat_thr(r_af, VC_LIM);
  assign w_af_d      = sat_thr(r_af, D_LIM);
  assign w_ae_d      = sat_thr(r_ae, D_LIM);
  assign w_main_word = r_main_mem[r_main_rd];
  assign w_main_vc   = w_main_word[DATA_SIZE-1 -: VC_BITS];
  assign w_main_full = (r_main_cnt == MAIN_FULL);
  assign w_main_fwd  = w_en && (r_main_cnt != '0) && (TW'(r_vc_cnt[w_main_vc]) < w_af_vc);
  // A full main FIFO still accepts a word when its head leaves in the same cycle.
  assign w_main_push = w_en && push_main && (!w_main_full || w_main_fwd);

  // VC eligibility and round-robin grant starting at the pointer
  always_comb begin
    w_elig    = '0;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_idx     = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      w_vc_head[v] = r_vc_mem[v][r_vc_rd[v]];
      w_vc_dst[v]  = w_vc_head[v][DATA_SIZE-1-VC_BITS -: D_BITS];
      w_elig[v]    = w_en && (r_vc_cnt[v] != '0) && (TW'(r_d_cnt[w_vc_dst[v]]) < w_af_d);
    end
    for (int i = 0; i < NUM_VC; i++) begin
      w_idx = r_rr + VC_BITS'(i);
      if (!w_gnt_vld && w_elig[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = w_idx;
      end
    end
  end

  // Per-FIFO push/pop strobes derived from the two transfers and the consumer
  always_comb begin
    w_vc_push = '0;
    w_vc_pop  = '0;
    w_d_push  = '0;
    w_d_pop   = '0;
    w_d_word  = w_vc_head[w_gnt];
    for (int v = 0; v < NUM_VC; v++) begin
      w_vc_push[v] = w_main_fwd && (w_main_vc == VC_BITS'(v));
      w_vc_pop[v]  = w_gnt_vld && (w_gnt == VC_BITS'(v));
    end
    for (int k = 0; k < NUM_DEST; k++) begin
      w_d_push[k] = w_gnt_vld && (w_vc_dst[w_gnt] == D_BITS'(k));
      w_d_pop[k]  = w_en && pop_d[k] && (r_d_cnt[k] != '0);
    end
  end

  // New error events this cycle and global non-empty detection
  always_comb begin
    w_new_err    = '0;
    w_new_err[0] = w_en && push_main && w_main_full && !w_main_fwd;
    w_any_ne     = (r_main_cnt != '0);
    for (int v = 0; v < NUM_VC; v++) begin
      w_new_err[1+v] = (w_vc_push[v] && (r_vc_cnt[v] == VC_FULL) && !w_vc_pop[v]) ||
                       (w_vc_pop[v] && (r_vc_cnt[v] == '0));
      w_any_ne       = w_any_ne || (r_vc_cnt[v] != '0);
    end
    for (int k = 0; k < NUM_DEST; k++) begin
      w_new_err[1+NUM_VC+k] = (w_en && pop_d[k] && (r_d_cnt[k] == '0)) ||
                              (w_d_push[k] && (r_d_cnt[k] == D_FULL) && !w_d_pop[k]);
      w_any_ne              = w_any_ne || (r_d_cnt[k] != '0);
    end
  end

  // FSM next state; init wins over everything except staying in INIT
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:   if (!init) w_state_nxt = S_IDLE;
      S_IDLE: begin
        if (init)            w_state_nxt = S_INIT;
        else if (|w_new_err) w_state_nxt = S_ERROR;
        else if (w_any_ne)   w_state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (init)            w_state_nxt = S_INIT;
        else if (|w_new_err) w_state_nxt = S_ERROR;
        else if (!w_any_ne)  w_state_nxt = S_IDLE;
      end
      S_ERROR:  if (init) w_state_nxt = S_INIT;
      default:  w_state_nxt = S_INIT;
    endcase
  end

  // FSM state, threshold latch, sticky errors and arbiter pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_INIT;
      r_af    <= TW'(VC_DEPTH - 1);
      r_ae    <= TW'(1);
      r_err   <= '0;
      r_rr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) begin
        r_af <= af_thr;
        r_ae <= ae_thr;
      end
      if (w_state_nxt == S_INIT) r_err <= '0;
      else                       r_err <= r_err | w_new_err;
      if (w_gnt_vld) r_rr <= w_gnt + 1'b1;
    end
  end

  // Main FIFO pointers and count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_wr  <= '0;
      r_main_rd  <= '0;
      r_main_cnt <= '0;
    end else begin
      if (w_main_push) r_main_wr <= r_main_wr + 1'b1;
      if (w_main_fwd)  r_main_rd <= r_main_rd + 1'b1;
      case ({w_main_push, w_main_fwd})
        2'b10:   r_main_cnt <= r_main_cnt + 1'b1;
        2'b01:   r_main_cnt <= r_main_cnt - 1'b1;
        default: r_main_cnt <= r_main_cnt;
      endcase
    end
  end

  // Main FIFO storage
  always_ff @(posedge clk) begin
    if (w_main_push) r_main_mem[r_main_wr] <= data_in;
  end

  // VC FIFO pointers and counts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        r_vc_wr[v]  <= '0;
        r_vc_rd[v]  <= '0;
        r_vc_cnt[v] <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        logic do_push, do_pop;
        do_push = w_vc_push[v] && ((r_vc_cnt[v] != VC_FULL) || w_vc_pop[v]);
        do_pop  = w_vc_pop[v] && (r_vc_cnt[v] != '0);
        if (do_push) r_vc_wr[v] <= r_vc_wr[v] + 1'b1;
        if (do_pop)  r_vc_rd[v] <= r_vc_rd[v] + 1'b1;
        case ({do_push, do_pop})
          2'b10:   r_vc_cnt[v] <= r_vc_cnt[v] + 1'b1;
          2'b01:   r_vc_cnt[v] <= r_vc_cnt[v] - 1'b1;
          default: r_vc_cnt[v] <= r_vc_cnt[v];
        endcase
      end
    end
  end

  // VC FIFO storage
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (w_vc_push[v] && ((r_vc_cnt[v] != VC_FULL) || w_vc_pop[v]))
        r_vc_mem[v][r_vc_wr[v]] <= w_main_word;
    end
  end

  // Destination FIFO pointers, counts and last-popped word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_DEST; k++) begin
        r_d_wr[k]  <= '0;
        r_d_rd[k]  <= '0;
        r_d_cnt[k] <= '0;
        r_hold[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_DEST; k++) begin
        logic do_push;
        do_push = w_d_push[k] && ((r_d_cnt[k] != D_FULL) || w_d_pop[k]);
        if (do_push) r_d_wr[k] <= r_d_wr[k] + 1'b1;
        if (w_d_pop[k]) begin
          r_d_rd[k] <= r_d_rd[k] + 1'b1;
          r_hold[k] <= r_d_mem[k][r_d_rd[k]];
        end
        case ({do_push, w_d_pop[k]})
          2'b10:   r_d_cnt[k] <= r_d_cnt[k] + 1'b1;
          2'b01:   r_d_cnt[k] <= r_d_cnt[k] - 1'b1;
          default: r_d_cnt[k] <= r_d_cnt[k];
        endcase
      end
    end
  end

  // Destination FIFO storage
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_DEST; k++) begin
      if (w_d_push[k] && ((r_d_cnt[k] != D_FULL) || w_d_pop[k]))
        r_d_mem[k][r_d_wr[k]] <= w_d_word;
    end
  end

  // Destination-facing outputs; an empty FIFO shows the word it last delivered
  always_comb begin
    data_out         = '0;
    empty_out        = '0;
    almost_empty_out = '0;
    for (int k = 0; k < NUM_DEST; k++) begin
      empty_out[k]        = (r_d_cnt[k] == '0);
      almost_empty_out[k] = (TW'(r_d_cnt[k]) <= w_ae_d);
      data_out[k*DATA_SIZE +: DATA_SIZE] = (r_d_cnt[k] == '0) ? r_hold[k] : r_d_mem[k][r_d_rd[k]];
    end
  end

  assign pause      = (TW'(r_main_cnt) >= w_af_main);
  assign error_out  = r_err;
  assign state_out  = r_state;
  assign idle_out   = (r_state == S_IDLE);
  assign active_out = (r_state == S_ACTIVE);

`ifdef VC_SWITCH_COUNT_EN
  logic [15:0] r_wcnt [NUM_DEST];

  // Successful pops per destination; cleared whenever the FSM is headed for INIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_DEST; k++) r_wcnt[k] <= '0;
    end else if (w_state_nxt == S_INIT) begin
      for (int k = 0; k < NUM_DEST; k++) r_wcnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_DEST; k++)
        if (w_d_pop[k]) r_wcnt[k] <= r_wcnt[k] + 16'd1;
    end
  end

  // Flatten the counters onto the output bus
  always_comb begin
    word_count = '0;
    for (int k = 0; k < NUM_DEST; k++) word_count[k*16 +: 16] = r_wcnt[k];
  end
`endif

endmodule

// File: tb/tb_vc_switch_n.sv
// Scoreboard bench for vc_switch_n with default parameters.
module tb_vc_switch_n;
  localparam int DS = 6;
  localparam int ND = 2;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          init;
  logic [TW-1:0] af_thr, ae_thr;
  logic          push_main;
  logic [DS-1:0] data_in;
  logic [ND-1:0] pop_d;
  logic [ND*DS-1:0] data_out;
  logic [ND-1:0] empty_out, almost_empty_out;
  logic          pause;
  logic [4:0]    error_out;
  logic [1:0]    state_out;
  logic          idle_out, active_out;
`ifdef VC_SWITCH_COUNT_EN
  logic [ND*16-1:0] word_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [DS-1:0] q0[$];
  logic [DS-1:0] q1[$];

  always #5 clk = ~clk;

  vc_switch_n dut (
    .clk(clk), .reset(reset), .init(init), .af_thr(af_thr), .ae_thr(ae_thr),
    .push_main(push_main), .data_in(data_in), .pop_d(pop_d), .data_out(data_out),
    .empty_out(empty_out), .almost_empty_out(almost_empty_out), .pause(pause),
    .error_out(error_out), .state_out(state_out), .idle_out(idle_out),
    .active_out(active_out)
`ifdef VC_SWITCH_COUNT_EN
    , .word_count(word_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},   32'(state_out), 32'h0);
    check({tag, "_empty"},   32'(empty_out), 32'h3);
    check({tag, "_data"},    32'(data_out), 32'h0);
    check({tag, "_aempty"},  32'(almost_empty_out), 32'h3);
    check({tag, "_pause"},   32'(pause), 32'h0);
    check({tag, "_err"},     32'(error_out), 32'h0);
    check({tag, "_idle"},    32'(idle_out), 32'h0);
    check({tag, "_active"},  32'(active_out), 32'h0);
  endtask

  task automatic push_word(input logic [DS-1:0] d);
    push_main = 1'b1;
    data_in   = d;
    tick();
    push_main = 1'b0;
  endtask

  task automatic pop_word(input int k);
    int t = 0;
    while (empty_out[k] && t < 50) begin
      tick();
      t++;
    end
    if (empty_out[k]) begin
      n_tests++;
      n_fail++;
      $display("FAIL pop%0d_timeout: empty_out still 1 after %0d cycles, required a word", k, t);
    end else begin
      pop_d[k] = 1'b1;
      tick();
      pop_d[k] = 1'b0;
    end
  endtask

  // Compares the head word against the scoreboard whenever a valid pop is presented.
  task automatic monitor_loop();
    logic [DS-1:0] got, exp;
    forever begin
      @(negedge clk);
      if (!reset && state_out != 2'b00) begin
        for (int k = 0; k < ND; k++) begin
          if (pop_d[k] && !empty_out[k]) begin
            got = data_out[k*DS +: DS];
            n_tests++;
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
              n_fail++;
              $display("FAIL dest%0d_word: got 0x%0h, required no word", k, got);
            end else begin
              if (k == 0) exp = q0.pop_front();
              else        exp = q1.pop_front();
              if (got !== exp) begin
                n_fail++;
                $display("FAIL dest%0d_word: got 0x%0h, required 0x%0h", k, got, exp);
              end
            end
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; init = 1'b0; af_thr = 5'd3; ae_thr = 5'd1;
    push_main = 1'b0; data_in = '0; pop_d = '0;
    fork
      monitor_loop();
    join_none
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");

    // Bring-up
    reset = 1'b0; init = 1'b1;
    tick();
    check("init_state", 32'(state_out), 32'h0);
    init = 1'b0;
    tick();
    check("up_state", 32'(state_out), 32'h1);
    check("up_idle", 32'(idle_out), 32'h1);
    check("up_empty", 32'(empty_out), 32'h3);
    check("up_err", 32'(error_out), 32'h0);

    // Single word latency: vc1, dest0
    q0.push_back(6'h2A);
    push_word(6'h2A);
    tick();
    check("lat_n1_empty0", 32'(empty_out[0]), 32'h1);
    check("lat_active", 32'(active_out), 32'h1);
    tick();
    check("lat_n2_empty0", 32'(empty_out[0]), 32'h0);
    check("lat_aempty0", 32'(almost_empty_out[0]), 32'h1);
    pop_word(0);
    tick();
    check("back_idle", 32'(idle_out), 32'h1);

    // Dest0 fills to 3, VC0 backs up to 3, VC1 still reaches dest1
    for (int i = 1; i <= 6; i++) begin
      q0.push_back(6'(i));
      push_word(6'(i));
    end
    repeat (6) tick();
    check("blk_empty0", 32'(empty_out[0]), 32'h0);
    check("blk_aempty0", 32'(almost_empty_out[0]), 32'h0);
    q1.push_back(6'h35);
    push_word(6'h35);
    repeat (4) tick();
    check("rr_bypass_empty1", 32'(empty_out[1]), 32'h0);
    q0.push_back(6'h07); push_word(6'h07);
    q0.push_back(6'h08); push_word(6'h08);
    repeat (3) tick();
    check("pause_cnt2", 32'(pause), 32'h0);
    q0.push_back(6'h09); push_word(6'h09);
    check("pause_cnt3", 32'(pause), 32'h1);
    pop_word(1);
    for (int i = 0; i < 9; i++) pop_word(0);
    repeat (4) tick();
    check("drain_idle", 32'(idle_out), 32'h1);
    check("drain_empty", 32'(empty_out), 32'h3);

    // Round-robin alternation between two backlogged VCs for dest0
    push_word(6'h01); push_word(6'h02); push_word(6'h03);
    repeat (5) tick();
    push_word(6'h04); push_word(6'h05); push_word(6'h21); push_word(6'h22);
    repeat (5) tick();
    q0.push_back(6'h01); q0.push_back(6'h02); q0.push_back(6'h03);
    q0.push_back(6'h21); q0.push_back(6'h04); q0.push_back(6'h22); q0.push_back(6'h05);
    for (int i = 0; i < 7; i++) pop_word(0);
    repeat (4) tick();
    check("rr_idle", 32'(idle_out), 32'h1);

    // Main overflow with forwarding blocked (af = 0)
    init = 1'b1; af_thr = 5'd0;
    tick();
    init = 1'b0;
    tick();
    check("af0_state", 32'(state_out), 32'h1);
    push_main = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = 6'(8'h10 + i);
      if (i < 4) q1.push_back(6'(8'h10 + i));
      tick();
    end
    push_main = 1'b0;
    check("ovf_err", 32'(error_out), 32'h01);
    check("ovf_state", 32'(state_out), 32'h3);
    check("ovf_pause", 32'(pause), 32'h1);
    init = 1'b1; af_thr = 5'd3;
    tick();
    check("clr_err", 32'(error_out), 32'h0);
    check("clr_state", 32'(state_out), 32'h0);
    init = 1'b0;
    tick();
    check("clr_idle_state", 32'(state_out), 32'h1);
    for (int i = 0; i < 4; i++) pop_word(1);
    repeat (4) tick();
    check("ovf_drop_empty", 32'(empty_out), 32'h3);
    check("ovf_drop_idle", 32'(idle_out), 32'h1);

    // Pop on an empty destination
    pop_d[1] = 1'b1;
    tick();
    pop_d[1] = 1'b0;
    check("popempty_err", 32'(error_out), 32'h10);
    check("popempty_state", 32'(state_out), 32'h3);

    // Traffic still flows in ERROR; reset lands mid-stream
    push_word(6'h2A);
    push_word(6'h15);
    tick();
    check("errstate_traffic", 32'(empty_out[0]), 32'h0);
    #3 reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    q0.delete();
    q1.delete();
    tick();
    reset = 1'b0;

`ifdef VC_SWITCH_COUNT_EN
    init = 1'b1; af_thr = 5'd3; ae_thr = 5'd1;
    tick();
    init = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(6'(i + 1));
      push_word(6'(i + 1));
    end
    for (int i = 0; i < 3; i++) pop_word(0);
    pop_d[0] = 1'b1;
    tick();
    pop_d[0] = 1'b0;
    check("wc_dest0", 32'(word_count[15:0]), 32'd3);
    check("wc_dest1", 32'(word_count[31:16]), 32'd0);
`endif

    check("sb_leftover", 32'(q0.size() + q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
